// File: rtl/scamp_uinstr_pkg.sv
// Microinstruction field map and fixed control words for the SCAMP CPU.
// Words are native: bit 15 is EO_bar, so the logical value is word ^ 16'h8000.
package scamp_uinstr_pkg;

    localparam int EO  = 15;
    localparam int EX  = 14;
    localparam int NX  = 13;
    localparam int EY  = 12;
    localparam int NY  = 11;
    localparam int F   = 10;
    localparam int NO  = 9;
    localparam int XI  = 8;
    localparam int II  = 7;
    localparam int MI  = 6;
    localparam int JC  = 5;
    localparam int JZ  = 4;
    localparam int JGT = 3;
    localparam int JLT = 2;

    localparam logic [15:0] NOP    = 16'h8000;
    localparam logic [15:0] FETCH0 = 16'h8040;
    localparam logic [15:0] FETCH1 = 16'hB4C0;

    typedef enum logic {
        SEQ_RUN    = 1'b0,
        SEQ_HALTED = 1'b1
    } seq_state_e;

endpackage

// File: rtl/jump_qualify.sv
// Combinational branch condition: the emitted jump bits qualified by ALU flags.
module jump_qualify (
    input  logic       enable,
    input  logic [3:0] jump_bits,
    input  logic       flag_z,
    input  logic       flag_lt,
    input  logic       flag_c,
    output logic       jump
);

    // jump_bits = {JC, JZ, JGT, JLT}
    assign jump = enable & ((jump_bits[3] & flag_c)
                          | (jump_bits[2] & flag_z)
                          | (jump_bits[1] & ~flag_z & ~flag_lt)
                          | (jump_bits[0] & flag_lt));

endmodule

// File: rtl/microsequencer.sv
// T-state sequencer: hard-wired fetch, ROM-driven execute steps, early end on
// an empty word, stall freeze and halt at instruction boundaries.
module microsequencer
    import scamp_uinstr_pkg::*;
#(
    parameter int OP_BITS = 8,
    parameter int T_BITS  = 3
) (
    input  logic                       clk,
    input  logic                       reset_bar,
    input  logic [OP_BITS-1:0]         opcode,
    input  logic [15:0]                rom_data,
    input  logic                       stall,
    input  logic                       halt_req,
    input  logic                       flag_z,
    input  logic                       flag_lt,
    input  logic                       flag_c,
    output logic [OP_BITS+T_BITS-1:0]  uaddr,
    output logic [15:0]                uinstr,
    output logic [T_BITS-1:0]          tstate,
    output logic                       instr_start,
    output logic                       jump_load,
    output logic                       halted
);

    localparam logic [0:0] RUN    = 1'(SEQ_RUN);
    localparam logic [0:0] HALTED = 1'(SEQ_HALTED);
    localparam logic [T_BITS-1:0] T_LAST = '1;

    logic [0:0]        state_reg, state_next;
    logic [T_BITS-1:0] tstate_reg, tstate_next;
    logic              active;
    logic              boundary;

    // Sequencing only happens when running, out of reset and not stalled.
    assign active   = reset_bar && (state_reg == RUN) && !stall;
    assign boundary = ((tstate_reg >= T_BITS'(2)) && (rom_data == NOP))
                   || (tstate_reg == T_LAST);

    always_comb begin
        uinstr = NOP;
        if (active) begin
            if (tstate_reg == T_BITS'(0))
                uinstr = FETCH0;
            else if (tstate_reg == T_BITS'(1))
                uinstr = FETCH1;
            else
                uinstr = rom_data;
        end
    end

    always_comb begin
        state_next  = state_reg;
        tstate_next = tstate_reg;
        if (state_reg == HALTED) begin
            tstate_next = '0;
            if (!halt_req)
                state_next = RUN;
        end else if (!stall) begin
            if (boundary) begin
                tstate_next = '0;
                if (halt_req)
                    state_next = HALTED;
            end else begin
                tstate_next = tstate_reg + T_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            state_reg  <= RUN;
            tstate_reg <= '0;
        end else begin
            state_reg  <= state_next;
            tstate_reg <= tstate_next;
        end
    end

    assign tstate      = tstate_reg;
    assign uaddr       = {opcode, tstate_reg};
    assign instr_start = active && (tstate_reg == T_BITS'(0));
    assign halted      = reset_bar && (state_reg == HALTED);

    jump_qualify u_jump_qualify (
        .enable    (active),
        .jump_bits (uinstr[JC:JLT]),
        .flag_z    (flag_z),
        .flag_lt   (flag_lt),
        .flag_c    (flag_c),
        .jump      (jump_load)
    );

endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: directed scenarios plus a randomized run checked
// against an instruction-level model of the sequencer.
module tb_microsequencer;

    localparam logic [15:0] W_NOP    = 16'h8000;
    localparam logic [15:0] W_FETCH0 = 16'h8040;
    localparam logic [15:0] W_FETCH1 = 16'hB4C0;

    logic        clk;
    logic        reset_bar;
    logic [7:0]  opcode;
    logic [15:0] rom_data;
    logic        stall, halt_req, flag_z, flag_lt, flag_c;
    logic [10:0] uaddr;
    logic [15:0] uinstr;
    logic [2:0]  tstate;
    logic        instr_start, jump_load, halted;

    logic [15:0] rom_mem [0:2047];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_step   = 0;
    bit          m_halted = 0;

    microsequencer #(.OP_BITS(8), .T_BITS(3)) dut (
        .clk(clk), .reset_bar(reset_bar), .opcode(opcode), .rom_data(rom_data),
        .stall(stall), .halt_req(halt_req), .flag_z(flag_z), .flag_lt(flag_lt),
        .flag_c(flag_c), .uaddr(uaddr), .uinstr(uinstr), .tstate(tstate),
        .instr_start(instr_start), .jump_load(jump_load), .halted(halted)
    );

    assign rom_data = rom_mem[uaddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: step count within the instruction plus a halted flag.
    function automatic logic [15:0] exp_uinstr();
        if (!reset_bar || m_halted || stall) return W_NOP;
        if (m_step == 0) return W_FETCH0;
        if (m_step == 1) return W_FETCH1;
        return rom_mem[{opcode, m_step[2:0]}];
    endfunction

    function automatic logic exp_jump(input logic [15:0] w);
        if (!reset_bar || m_halted || stall) return 1'b0;
        return (w[5] & flag_c) | (w[4] & flag_z) | (w[3] & !flag_z & !flag_lt) | (w[2] & flag_lt);
    endfunction

    task automatic tick();
        logic [15:0] w;
        w = rom_mem[{opcode, m_step[2:0]}];
        @(posedge clk);
        if (!reset_bar) begin
            m_step = 0;
            m_halted = 0;
        end else if (m_halted) begin
            m_step = 0;
            if (!halt_req) m_halted = 0;
        end else if (!stall) begin
            if ((m_step >= 2 && w == W_NOP) || m_step == 7) begin
                m_step = 0;
                if (halt_req) m_halted = 1;
            end else begin
                m_step = m_step + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_bar = 0; stall = 0; halt_req = 0; opcode = 8'h01;
        flag_z = 1; flag_lt = 1; flag_c = 1;
        tick(); tick(); #1;
        n_checks++; if (uinstr !== W_NOP) begin n_fail++; $display("FAIL reset_uinstr: got %h want %h", uinstr, W_NOP); end
        n_checks++; if (tstate !== 3'd0) begin n_fail++; $display("FAIL reset_tstate: got %0d want 0", tstate); end
        n_checks++; if (instr_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", instr_start); end
        n_checks++; if (jump_load !== 1'b0) begin n_fail++; $display("FAIL reset_jump: got %b want 0", jump_load); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        flag_z = 0; flag_lt = 0; flag_c = 0;
    endtask

    task automatic test_short_instr();
        rom_mem[{8'h01, 3'd2}] = W_NOP;
        opcode = 8'h01; reset_bar = 1; #1;
        n_checks++; if (uinstr !== W_FETCH0) begin n_fail++; $display("FAIL short_t0_uinstr: got %h want %h", uinstr, W_FETCH0); end
        n_checks++; if (instr_start !== 1'b1) begin n_fail++; $display("FAIL short_t0_start: got %b want 1", instr_start); end
        tick();
        n_checks++; if (uinstr !== W_FETCH1) begin n_fail++; $display("FAIL short_t1_uinstr: got %h want %h", uinstr, W_FETCH1); end
        n_checks++; if (instr_start !== 1'b0) begin n_fail++; $display("FAIL short_t1_start: got %b want 0", instr_start); end
        tick();
        n_checks++; if (uaddr !== 11'h00A) begin n_fail++; $display("FAIL short_t2_uaddr: got %h want 00a", uaddr); end
        n_checks++; if (uinstr !== W_NOP) begin n_fail++; $display("FAIL short_t2_uinstr: got %h want %h", uinstr, W_NOP); end
        tick();
        n_checks++; if (tstate !== 3'd0) begin n_fail++; $display("FAIL short_end_tstate: got %0d want 0", tstate); end
    endtask

    task automatic test_full_length();
        for (int t = 2; t < 8; t++) rom_mem[{8'h02, 3'(t)}] = 16'h8000 | 16'(t << 8);
        opcode = 8'h02; #1;
        for (int t = 0; t < 8; t++) begin
            n_checks++; if (tstate !== 3'(t)) begin n_fail++; $display("FAIL full_tstate: got %0d want %0d", tstate, t); end
            if (t == 7) begin
                n_checks++; if (uaddr !== 11'h017) begin n_fail++; $display("FAIL full_t7_uaddr: got %h want 017", uaddr); end
            end
            tick();
        end
        n_checks++; if (tstate !== 3'd0) begin n_fail++; $display("FAIL full_wrap: got %0d want 0", tstate); end
    endtask

    task automatic test_stall();
        tick();
        stall = 1; flag_z = 1; flag_lt = 1; flag_c = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (uinstr !== W_NOP) begin n_fail++; $display("FAIL stall_uinstr: got %h want %h", uinstr, W_NOP); end
            n_checks++; if (tstate !== 3'd1) begin n_fail++; $display("FAIL stall_tstate: got %0d want 1", tstate); end
            n_checks++; if (jump_load !== 1'b0) begin n_fail++; $display("FAIL stall_jump: got %b want 0", jump_load); end
            tick();
        end
        stall = 0; flag_z = 0; flag_lt = 0; flag_c = 0; #1;
        n_checks++; if (uinstr !== W_FETCH1) begin n_fail++; $display("FAIL stall_reissue: got %h want %h", uinstr, W_FETCH1); end
        tick();
        n_checks++; if (tstate !== 3'd2) begin n_fail++; $display("FAIL stall_next: got %0d want 2", tstate); end
        repeat (6) tick();
        n_checks++; if (tstate !== 3'd0) begin n_fail++; $display("FAIL stall_finish: got %0d want 0", tstate); end
    endtask

    task automatic test_jump();
        logic [15:0] words [10] = '{16'h8010, 16'h8010, 16'h8004, 16'h8004, 16'h8008,
                                   16'h8008, 16'h8008, 16'h8020, 16'h0010, 16'h803C};
        logic [2:0]  flags [10] = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b000,
                                   3'b100, 3'b010, 3'b001, 3'b100, 3'b000};
        logic        want  [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        opcode = 8'h03;
        rom_mem[{8'h03, 3'd3}] = W_NOP;
        for (int i = 0; i < 10; i++) begin
            rom_mem[{8'h03, 3'd2}] = words[i];
            flag_z = 1; flag_lt = 1; flag_c = 1; #1;
            n_checks++; if (jump_load !== 1'b0) begin n_fail++; $display("FAIL jump_fetch0 case %0d: got %b want 0", i, jump_load); end
            tick(); tick();
            {flag_z, flag_lt, flag_c} = flags[i]; #1;
            n_checks++; if (jump_load !== want[i]) begin n_fail++; $display("FAIL jump_cond case %0d word %h: got %b want %b", i, words[i], jump_load, want[i]); end
            stall = 1; #1;
            n_checks++; if (jump_load !== 1'b0) begin n_fail++; $display("FAIL jump_stalled case %0d: got %b want 0", i, jump_load); end
            stall = 0;
            tick(); tick();
            n_checks++; if (tstate !== 3'd0) begin n_fail++; $display("FAIL jump_end case %0d: got %0d want 0", i, tstate); end
        end
        flag_z = 0; flag_lt = 0; flag_c = 0;
    endtask

    task automatic test_halt();
        opcode = 8'h04;
        rom_mem[{8'h04, 3'd2}] = 16'h8100;
        rom_mem[{8'h04, 3'd3}] = 16'h8200;
        rom_mem[{8'h04, 3'd4}] = 16'h8300;
        rom_mem[{8'h04, 3'd5}] = W_NOP;
        halt_req = 0;
        tick(); tick(); tick();
        halt_req = 1; #1;
        n_checks++; if (halted !== 1'b0 || tstate !== 3'd3) begin n_fail++; $display("FAIL halt_t3: got halted=%b t=%0d want 0/3", halted, tstate); end
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_t4: got %b want 0", halted); end
        tick();
        n_checks++; if (uinstr !== W_NOP || tstate !== 3'd5) begin n_fail++; $display("FAIL halt_dead: got %h t=%0d want %h t=5", uinstr, tstate, W_NOP); end
        tick();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_entered: got %b want 1", halted); end
        n_checks++; if (uinstr !== W_NOP) begin n_fail++; $display("FAIL halt_uinstr: got %h want %h", uinstr, W_NOP); end
        n_checks++; if (instr_start !== 1'b0) begin n_fail++; $display("FAIL halt_start: got %b want 0", instr_start); end
        stall = 1;
        tick();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got %b want 1", halted); end
        halt_req = 0; #1;
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_release_cycle: got %b want 1", halted); end
        tick();
        stall = 0; #1;
        n_checks++; if (halted !== 1'b0 || uinstr !== W_FETCH0 || instr_start !== 1'b1) begin n_fail++; $display("FAIL halt_resume: got halted=%b uinstr=%h start=%b want 0/%h/1", halted, uinstr, instr_start, W_FETCH0); end
    endtask

    task automatic test_reset_mid();
        opcode = 8'h02; #1;
        repeat (4) tick();
        n_checks++; if (tstate !== 3'd4) begin n_fail++; $display("FAIL rmid_t4: got %0d want 4", tstate); end
        reset_bar = 0; #1;
        n_checks++; if (uinstr !== W_NOP) begin n_fail++; $display("FAIL rmid_forced: got %h want %h", uinstr, W_NOP); end
        tick();
        n_checks++; if (tstate !== 3'd0 || uinstr !== W_NOP) begin n_fail++; $display("FAIL rmid_after: got t=%0d %h want 0/%h", tstate, uinstr, W_NOP); end
        reset_bar = 1; #1;
        n_checks++; if (uinstr !== W_FETCH0 || instr_start !== 1'b1) begin n_fail++; $display("FAIL rmid_release: got %h start=%b want %h/1", uinstr, instr_start, W_FETCH0); end
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int a = 0; a < 64; a++)
            rom_mem[a] = ($urandom_range(0, 2) == 0) ? W_NOP : 16'($urandom);
        for (int c = 0; c < 600; c++) begin
            reset_bar = ($urandom_range(0, 39) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            halt_req  = ($urandom_range(0, 7) == 0);
            flag_z    = 1'($urandom); flag_lt = 1'($urandom); flag_c = 1'($urandom);
            if (m_step == 0 && $urandom_range(0, 1) == 1) opcode = 8'($urandom_range(0, 7));
            #1;
            w = exp_uinstr();
            n_checks++; if (uinstr !== w) begin n_fail++; $display("FAIL rand_uinstr cyc %0d: got %h want %h", c, uinstr, w); end
            n_checks++; if (tstate !== m_step[2:0]) begin n_fail++; $display("FAIL rand_tstate cyc %0d: got %0d want %0d", c, tstate, m_step); end
            n_checks++; if (uaddr !== {opcode, m_step[2:0]}) begin n_fail++; $display("FAIL rand_uaddr cyc %0d: got %h want %h", c, uaddr, {opcode, m_step[2:0]}); end
            n_checks++; if (jump_load !== exp_jump(w)) begin n_fail++; $display("FAIL rand_jump cyc %0d: got %b want %b", c, jump_load, exp_jump(w)); end
            n_checks++; if (instr_start !== (reset_bar && !m_halted && !stall && m_step == 0)) begin n_fail++; $display("FAIL rand_start cyc %0d: got %b", c, instr_start); end
            n_checks++; if (halted !== (reset_bar && m_halted)) begin n_fail++; $display("FAIL rand_halted cyc %0d: got %b want %b", c, halted, reset_bar && m_halted); end
            tick();
        end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) rom_mem[a] = W_NOP;
        test_reset();
        test_short_instr();
        test_full_length();
        test_stall();
        test_jump();
        test_halt();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Steps the CPU through microcode. Holds the T-state counter, forms the microcode ROM address from the IR opcode, and drives the 16-bit control word into the Control decoder.
- Hard-wires the two fetch steps.
- Ends instructions early on an empty control word.
- Qualifies the jump bits against the ALU flags to produce the PC-load strobe.
- Supports memory-wait stalls and halt at instruction boundaries.

Parameters:
- OP_BITS, 8, opcode width taken from the IR high byte.
- T_BITS, 3, T-state counter width; instruction length is at most 2^T_BITS steps.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset_bar, input, 1, synchronous active-low reset.
- opcode, input, OP_BITS, IR[15:8].
- rom_data, input, 16, microcode ROM word in native Control encoding (bit 15 = EO_bar, so it is stored inverted).
- stall, input, 1, memory wait; freezes sequencing.
- halt_req, input, 1, request to stop at the next instruction boundary.
- flag_z, input, 1, ALU zero flag.
- flag_lt, input, 1, ALU negative flag.
- flag_c, input, 1, ALU carry flag.
- uaddr, output, OP_BITS+T_BITS, ROM address = {opcode, tstate}.
- uinstr, output, 16, native control word to Control.
- tstate, output, T_BITS, current step.
- instr_start, output, 1, high during T0 of every executed instruction.
- jump_load, output, 1, PC load strobe.
- halted, output, 1, high in the HALTED state.

Behaviour:
- Constants, in native encoding:
  - NOP = 16'h8000 (logical 0).
  - FETCH0 = 16'h8040 (PO|MI).
  - FETCH1 = 16'hB4C0 (RO|II|P+).
- States: RUN, HALTED.
- Reset (reset_bar low at a clock edge):
  - state=RUN, tstate=0.
  - While reset_bar is low: uinstr=NOP, jump_load=0, instr_start=0, halted=0.
  - Reset mid-instruction abandons it; the first cycle after release is T0.
- uinstr in RUN, not stalled:
  - T0 gives FETCH0.
  - T1 gives FETCH1.
  - T≥2 gives rom_data.
- uaddr is always {opcode, tstate}. It is combinational; the ROM is asynchronous.
- Next T-state in RUN:
  - stall=1: tstate holds and uinstr=NOP, so no MI/II/XI/YI/P+ and no jump. After the stall ends the same step is reissued with its full word.
  - tstate≥2 and rom_data==NOP: end of instruction; next tstate is 0. That cycle is a dead NOP cycle.
  - tstate==2^T_BITS-1: wrap to 0.
  - Otherwise tstate+1.
- Halt:
  - At any edge where next tstate would be 0 and halt_req=1, go to HALTED with tstate=0.
  - HALTED: uinstr=NOP, halted=1, instr_start=0.
  - Leave HALTED when halt_req=0 at an edge; the next cycle is T0 in RUN.
  - Mid-instruction halt_req has no effect until the boundary. stall is ignored in HALTED.
- instr_start = RUN & tstate==0 & !stall & reset_bar.
- jump_load is combinational, using the logical jump bits of the emitted uinstr (JC bit5, JZ bit4, JGT bit3, JLT bit2):
  - (JC&flag_c) | (JZ&flag_z) | (JGT&!flag_z&!flag_lt) | (JLT&flag_lt).
  - Forced 0 when stalled, halted or in reset.
  - When EO is active (native bit15=0), jump bits overlap no ALU fields, so they are honoured regardless of EO.
- Simultaneous events:
  - stall at a boundary: stall wins; tstate holds and halt is re-evaluated next edge.
  - halt_req together with the wrap at step 7: HALTED.

Decomposition:
- Shared package `scamp_uinstr_pkg`:
  - Field bit constants: EO, EX, NX, EY, NY, F, NO, MI, II, XI, JC, JZ, JGT, JLT.
  - NOP, FETCH0, FETCH1 native words.
  - The run/halted state enum.
  - These same constants are reused by the Control bench.
- One sub-module is natural: `jump_qualify`, the combinational flags-vs-jump-bits condition.

Test Plan:
- Reset, release; opcode=8'h01, ROM returns 16'h8000 at T2. Expect: T0 uinstr=8040, instr_start=1; T1 B4C0; T2 uaddr=0x00A, uinstr=8000; next cycle tstate=0.
- Full-length instruction, ROM never NOP for opcode 8'h02. Expect: tstate steps 0..7 then wraps to 0; uaddr at T7 = 0x017.
- stall=1 for 3 cycles at T1. Expect: uinstr=8000, tstate=1 held, jump_load=0; then FETCH1 is reissued and T2 follows.
- ROM T2 word with JZ set (logical 0x0010, native 0x8010). Expect: flag_z=1 gives jump_load=1; flag_z=0 gives 0. Same check for JLT with flag_lt and JGT with z=0, lt=0.
- halt_req raised at T3 of an 5-step instruction. Expect: completes through the NOP end, then halted=1, uinstr=8000. Drop halt_req: next cycle T0 with FETCH0.
- reset_bar low at T4. Expect: next cycle uinstr=8000, tstate=0. After release: FETCH0, instr_start=1.
